// File: rtl/stack_lifo_sync_if.sv
// Interface for the stack_lifo_sync LIFO: request/data, status and error lines.
// The almost_full line is present only when STACK_ALMOST_FULL_EN is defined.
interface stack_lifo_sync_if #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] din;
    logic              err_clr;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
`ifdef STACK_ALMOST_FULL_EN
    logic              almost_full;
`endif

    modport master (
        output push, pop, din, err_clr,
        input  dout, dout_valid, empty, full, count, overflow, underflow
`ifdef STACK_ALMOST_FULL_EN
        , input almost_full
`endif
    );

    modport slave (
        input  push, pop, din, err_clr,
        output dout, dout_valid, empty, full, count, overflow, underflow
`ifdef STACK_ALMOST_FULL_EN
        , output almost_full
`endif
    );
endinterface

// File: rtl/stack_lifo_sync.sv
// Synchronous LIFO stack with registered pop output, exchange and sticky errors.
// Define STACK_ALMOST_FULL_EN to add the almost_full status output (count >= AF_LEVEL).
module stack_lifo_sync #(
    parameter int DATA_W   = 19,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4
) (
    input  logic              clk,
    input  logic              CLR,
    stack_lifo_sync_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("stack_lifo_sync: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q, dout_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              empty_w, full_w;
    logic [CNT_W-1:0]  count_m1;
    logic [PTR_W-1:0]  sp, top;
    logic              wr_en, rd_en, ovf_evt, unf_evt;
    logic [PTR_W-1:0]  wr_addr;

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == CNT_W'(DEPTH));
    assign count_m1 = count_q - CNT_W'(1);
    // Low pointer bits are only used for writes when not full, so truncation is safe.
    assign sp       = count_q[PTR_W-1:0];
    assign top      = count_m1[PTR_W-1:0];

    always_comb begin
        count_d      = count_q;
        dout_valid_d = 1'b0;
        ovf_evt      = 1'b0;
        unf_evt      = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        wr_addr      = sp;
        case ({bus.push, bus.pop})
            2'b10: begin
                if (!full_w) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    ovf_evt = 1'b1;
                end
            end
            2'b01: begin
                if (!empty_w) begin
                    rd_en        = 1'b1;
                    count_d      = count_m1;
                    dout_valid_d = 1'b1;
                end else begin
                    unf_evt = 1'b1;
                end
            end
            2'b11: begin
                // Exchange replaces the top in place; empty degrades to a plain push.
                if (!empty_w) begin
                    rd_en        = 1'b1;
                    wr_en        = 1'b1;
                    wr_addr      = top;
                    dout_valid_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    count_d = CNT_W'(1);
                    unf_evt = 1'b1;
                end
            end
            default: ;
        endcase
        overflow_d  = (overflow_q  & ~bus.err_clr) | ovf_evt;
        underflow_d = (underflow_q & ~bus.err_clr) | unf_evt;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.din;
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            if (rd_en) begin
                dout_q <= mem[top];
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.empty      = empty_w;
    assign bus.full       = full_w;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;

`ifdef STACK_ALMOST_FULL_EN
    if (AF_LEVEL > DEPTH || AF_LEVEL == 0) begin : g_af_chk
        $error("stack_lifo_sync: AF_LEVEL must be in 1..DEPTH");
    end
    localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);
    assign bus.almost_full = (count_q >= AF_CNT);
`endif
endmodule
